// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - MIPS opcode values (6-bit IR[31:26] field)
//   - FSM state encodings (4-bit, widened by the top to STATE_W)
//   - datapath select encodings for alu_op, alu_src_b and pc_src
package mc_ctrl_pkg;

  // Opcodes understood by the sequencer
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // FSM state encodings
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC     = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_ADDI_EX  = 4'd9;
  localparam logic [3:0] S_ADDI_WB  = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_JAL_WB   = 4'd13;
  localparam logic [3:0] S_FAULT    = 4'd14;

  // ALU operation class
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OTHER = 2'b11
  } alu_op_e;

  // ALU B operand select
  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_IMM4 = 2'b11
  } src_b_e;

  // PC source select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/mc_ctrl_timeout.sv
// Wait-state watchdog for the multi-cycle control unit.
//   clk     : clock
//   rst_n   : synchronous active-low reset, clears the counter
//   start   : entering a wait state this cycle, clears the counter
//   busy    : currently in a wait state
//   ready   : memory completes the access this cycle
//   expire  : last permitted cycle has passed without ready
// TIMEOUT = 0 disables expiry entirely.
module mc_ctrl_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  generate
    if (TIMEOUT > 0) begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      // Ready in the same cycle always wins over expiry.
      assign expire = busy && !ready && (cnt_q == LAST);
    end else begin : g_off
      assign expire = 1'b0;
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy && !ready && !expire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style sequencer for a multi-cycle MIPS core: one instruction runs
// through FETCH, DECODE and 1-3 further states, with memory-ready handshakes
// guarded by a timeout that parks the FSM in a sticky FAULT state.
//   clk, rst_n          : clock, synchronous active-low reset
//   opcode, mem_ready   : IR opcode field, memory completion handshake
//   mem_*_n, iord       : memory strobes (active low) and address select
//   ir_write, pc_write* : IR / PC load enables, pc_src PC mux select
//   alu_src_a/b, alu_op : ALU operand selects and operation class
//   reg_dst, mem_to_reg, reg_write, jal : register-file writeback controls
//   illegal_op, fault   : unknown-opcode pulse, sticky memory timeout
//   state_o             : current state for debug
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int TIMEOUT  = 16,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_cs_n,
  output logic                mem_read_n,
  output logic                mem_write_n,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_beq,
  output logic                pc_write_bne,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                jal,
  output logic                illegal_op,
  output logic                fault,
  output logic [STATE_W-1:0]  state_o
);

  localparam logic [STATE_W-1:0] ST_IDLE     = STATE_W'(S_IDLE);
  localparam logic [STATE_W-1:0] ST_FETCH    = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE   = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_MEM_ADDR = STATE_W'(S_MEM_ADDR);
  localparam logic [STATE_W-1:0] ST_MEM_RD   = STATE_W'(S_MEM_RD);
  localparam logic [STATE_W-1:0] ST_MEM_WB   = STATE_W'(S_MEM_WB);
  localparam logic [STATE_W-1:0] ST_MEM_WR   = STATE_W'(S_MEM_WR);
  localparam logic [STATE_W-1:0] ST_EXEC     = STATE_W'(S_EXEC);
  localparam logic [STATE_W-1:0] ST_ALU_WB   = STATE_W'(S_ALU_WB);
  localparam logic [STATE_W-1:0] ST_ADDI_EX  = STATE_W'(S_ADDI_EX);
  localparam logic [STATE_W-1:0] ST_ADDI_WB  = STATE_W'(S_ADDI_WB);
  localparam logic [STATE_W-1:0] ST_BRANCH   = STATE_W'(S_BRANCH);
  localparam logic [STATE_W-1:0] ST_JUMP     = STATE_W'(S_JUMP);
  localparam logic [STATE_W-1:0] ST_JAL_WB   = STATE_W'(S_JAL_WB);
  localparam logic [STATE_W-1:0] ST_FAULT    = STATE_W'(S_FAULT);

  localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] OPC_JAL   = OPCODE_W'(OP_JAL);
  localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OPC_BNE   = OPCODE_W'(OP_BNE);
  localparam logic [OPCODE_W-1:0] OPC_ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);

  logic [STATE_W-1:0] state_q, state_d;
  logic               to_start, to_busy, to_expire;

  function automatic logic is_wait(input logic [STATE_W-1:0] s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

  // The watchdog restarts whenever a wait state is newly entered, including
  // the direct MEM_WR -> FETCH hop between two wait states.
  assign to_busy  = is_wait(state_q);
  assign to_start = (state_d != state_q) && is_wait(state_d);

  mc_ctrl_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (to_start),
    .busy   (to_busy),
    .ready  (mem_ready),
    .expire (to_expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)      state_d = ST_DECODE;
        else if (to_expire) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        case (opcode)
          OPC_LW, OPC_SW:   state_d = ST_MEM_ADDR;
          OPC_RTYPE:        state_d = ST_EXEC;
          OPC_ADDI:         state_d = ST_ADDI_EX;
          OPC_BEQ, OPC_BNE: state_d = ST_BRANCH;
          OPC_J:            state_d = ST_JUMP;
          OPC_JAL:          state_d = ST_JAL_WB;
          default:          state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: state_d = (opcode == OPC_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready)      state_d = ST_MEM_WB;
        else if (to_expire) state_d = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (mem_ready)      state_d = ST_FETCH;
        else if (to_expire) state_d = ST_FAULT;
      end
      ST_EXEC:     state_d = ST_ALU_WB;
      ST_ADDI_EX:  state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_ALU_WB, ST_ADDI_WB,
      ST_BRANCH, ST_JUMP, ST_JAL_WB:
                   state_d = ST_FETCH;
      ST_FAULT:    state_d = ST_FAULT;
      // Unused encodings recover through IDLE.
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_cs_n     = 1'b1;
    mem_read_n   = 1'b1;
    mem_write_n  = 1'b1;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    pc_src       = PCSRC_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    alu_op       = ALU_ADD;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    jal          = 1'b0;
    illegal_op   = 1'b0;
    fault        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_cs_n   = 1'b0;
        mem_read_n = 1'b0;
        alu_src_b  = SRCB_FOUR;
        // IR and PC only latch once the instruction word is actually there.
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_IMM4;
        illegal_op = !(opcode inside {OPC_RTYPE, OPC_J, OPC_JAL, OPC_BEQ,
                                      OPC_BNE, OPC_ADDI, OPC_LW, OPC_SW});
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_cs_n   = 1'b0;
        mem_read_n = 1'b0;
        iord       = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_cs_n    = 1'b0;
        mem_write_n = 1'b0;
        iord        = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_ADDI_WB: reg_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = ALU_SUB;
        pc_src       = PCSRC_ALUOUT;
        pc_write_beq = (opcode == OPC_BEQ);
        pc_write_bne = (opcode == OPC_BNE);
      end
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      ST_JAL_WB: begin
        pc_src    = PCSRC_JUMP;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        jal       = 1'b1;
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control (TIMEOUT = 4).
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_cs_n, mem_read_n, mem_write_n, iord, ir_write, pc_write;
  logic       pc_write_beq, pc_write_bne, alu_src_a;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       reg_dst, mem_to_reg, reg_write, jal, illegal_op, fault;
  logic [3:0] state_o;

  multicycle_control #(.OPCODE_W(6), .TIMEOUT(TO), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_cs_n(mem_cs_n), .mem_read_n(mem_read_n), .mem_write_n(mem_write_n),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_beq(pc_write_beq), .pc_write_bne(pc_write_bne), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .jal(jal), .illegal_op(illegal_op), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic cs_n; logic rd_n; logic wr_n; logic iord; logic irw; logic pcw;
    logic beq; logic bne; logic [1:0] pcs; logic sa; logic [1:0] sb;
    logic [1:0] aop; logic rdst; logic m2r; logic rw; logic jal;
    logic ill; logic flt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         AD = 6'b001000, BQ = 6'b000100, BN = 6'b000101,
                         JP = 6'b000010, JL = 6'b000011;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {LW, SW, RT, AD, BQ, BN, JP, JL};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Control word the spec's per-state table requires.
  function automatic obs_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                   input logic rdy);
    obs_t o;
    o = '0;
    o.st = st; o.cs_n = 1'b1; o.rd_n = 1'b1; o.wr_n = 1'b1;
    case (st)
      S_FETCH:    begin o.cs_n = 0; o.rd_n = 0; o.sb = 2'b01; o.irw = rdy; o.pcw = rdy; end
      S_DECODE:   begin o.sb = 2'b11; o.ill = !is_legal(op); end
      S_MEM_ADDR: begin o.sa = 1; o.sb = 2'b10; end
      S_MEM_RD:   begin o.cs_n = 0; o.rd_n = 0; o.iord = 1; end
      S_MEM_WB:   begin o.rw = 1; o.m2r = 1; end
      S_MEM_WR:   begin o.cs_n = 0; o.wr_n = 0; o.iord = 1; end
      S_EXEC:     begin o.sa = 1; o.aop = 2'b10; end
      S_ALU_WB:   begin o.rw = 1; o.rdst = 1; end
      S_ADDI_EX:  begin o.sa = 1; o.sb = 2'b10; end
      S_ADDI_WB:  o.rw = 1;
      S_BRANCH:   begin o.sa = 1; o.aop = 2'b01; o.pcs = 2'b01;
                        o.beq = (op == BQ); o.bne = (op == BN); end
      S_JUMP:     begin o.pcs = 2'b10; o.pcw = 1; end
      S_JAL_WB:   begin o.pcs = 2'b10; o.pcw = 1; o.rw = 1; o.jal = 1; end
      S_FAULT:    o.flt = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle and queue what the DUT must show during it.
  task automatic step(input logic [3:0] st, input logic rdy, input logic rstv);
    mem_ready = rdy;
    rst_n     = rstv;
    exp_q.push_back(exp_out(st, opcode, rdy));
    @(posedge clk); #1;
  endtask

  task automatic reset_from(input logic [3:0] st, input logic rdy);
    step(st, rdy, 1'b0);
    step(S_IDLE, rnd(), 1'b0);
    step(S_IDLE, rnd(), 1'b1);
    $display("reset from state %0d", st);
  endtask

  // One instruction starting in FETCH: fw stall cycles on fetch, mw on memory.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    logic [3:0] wst;
    opcode = 6'($urandom);
    for (int k = 0; k < fw; k++) step(S_FETCH, 1'b0, 1'b1);
    step(S_FETCH, 1'b1, 1'b1);
    opcode = op;
    step(S_DECODE, rnd(), 1'b1);
    if (op == LW || op == SW) begin
      step(S_MEM_ADDR, rnd(), 1'b1);
      wst = (op == LW) ? S_MEM_RD : S_MEM_WR;
      for (int k = 0; k < mw; k++) step(wst, 1'b0, 1'b1);
      step(wst, 1'b1, 1'b1);
      if (op == LW) step(S_MEM_WB, rnd(), 1'b1);
    end else if (op == RT) begin
      step(S_EXEC, rnd(), 1'b1); step(S_ALU_WB, rnd(), 1'b1);
    end else if (op == AD) begin
      step(S_ADDI_EX, rnd(), 1'b1); step(S_ADDI_WB, rnd(), 1'b1);
    end else if (op == BQ || op == BN) begin
      step(S_BRANCH, rnd(), 1'b1);
    end else if (op == JP) begin
      step(S_JUMP, rnd(), 1'b1);
    end else if (op == JL) begin
      step(S_JAL_WB, rnd(), 1'b1);
    end
    $display("instr op=%b fetch_wait=%0d mem_wait=%0d", op, fw, mw);
  endtask

  // Monitor: every cycle the scoreboard has an entry for, compare it.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state_o, mem_cs_n, mem_read_n, mem_write_n, iord, ir_write,
           pc_write, pc_write_beq, pc_write_bne, pc_src, alu_src_a,
           alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, jal,
           illegal_op, fault};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL ctrl_word t=%0t: got %h (state %0d) required %h (state %0d)",
                    $time, a, a.st, e, e.st);
    end
  end

  initial begin
    logic [5:0] legal_ops[8];
    logic [5:0] op;
    int fw, mw;
    legal_ops = '{LW, SW, RT, AD, BQ, BN, JP, JL};
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0;
    @(posedge clk); #1;
    step(S_IDLE, 1'b0, 1'b0);
    step(S_IDLE, 1'b1, 1'b1);

    // Directed cases
    run_instr(RT, 0, 0);
    run_instr(LW, 0, 3);
    run_instr(BN, 0, 0);
    run_instr(BQ, 0, 0);
    run_instr(JL, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(RT, TO - 1, 0);          // ready on the last allowed cycle
    run_instr(SW, 1, TO - 1);
    run_instr(AD, TO - 1, 0);          // counter must restart after MEM_WR
    run_instr(JP, 0, 0);

    // Randomized instruction stream, stalls always inside the budget
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TO - 1) : 0;
      mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TO - 1) : 0;
      run_instr(op, fw, mw);
    end

    // Fetch timeout -> FAULT, reset recovers
    opcode = 6'($urandom);
    for (int k = 0; k < TO; k++) step(S_FETCH, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(S_FAULT, rnd(), 1'b1);
    reset_from(S_FAULT, rnd());

    // Memory-read timeout -> FAULT
    step(S_FETCH, 1'b1, 1'b1);
    opcode = LW;
    step(S_DECODE, rnd(), 1'b1);
    step(S_MEM_ADDR, rnd(), 1'b1);
    for (int k = 0; k < TO; k++) step(S_MEM_RD, 1'b0, 1'b1);
    step(S_FAULT, 1'b1, 1'b1);
    reset_from(S_FAULT, 1'b1);

    // Memory-write timeout -> FAULT
    step(S_FETCH, 1'b1, 1'b1);
    opcode = SW;
    step(S_DECODE, rnd(), 1'b1);
    step(S_MEM_ADDR, rnd(), 1'b1);
    for (int k = 0; k < TO; k++) step(S_MEM_WR, 1'b0, 1'b1);
    step(S_FAULT, 1'b0, 1'b1);
    reset_from(S_FAULT, 1'b0);

    // Reset wins over a completing access
    step(S_FETCH, 1'b1, 1'b1);
    opcode = LW;
    step(S_DECODE, rnd(), 1'b1);
    step(S_MEM_ADDR, rnd(), 1'b1);
    step(S_MEM_RD, 1'b0, 1'b1);
    reset_from(S_MEM_RD, 1'b1);
    run_instr(RT, 0, 0);

    @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
